br_dump: RTL and testbench
==========================

# br_dump

Register-bank read-out engine for the processor's debug path. On a start request it walks the register bank read port from address 0 to REG_COUNT-1, capturing each word from the bank's asynchronous read data and presenting it on a valid/ready stream together with its address. It sits beside the register bank and owns one read port (a1/rd1 side) while the datapath keeps the write port. It is the reader for the bank's write-side traffic in debug and self-check flows.

## Interface
- DATA_W, 32, register word width
- ADDR_W, 5, register address width
- REG_COUNT, 32, registers dumped per run (≤ 2**ADDR_W)
- ZERO_X0, 1, when 1 address 0 is emitted as 0 regardless of rd_data

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel of a run in progress
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse after the last word handshakes
- rd_addr  out  ADDR_W  address to bank read port (a1)
- rd_data  in  DATA_W  bank read data (rd1), combinational w.r.t. rd_addr
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts word
- out_addr  out  ADDR_W  address of word on out_data
- out_data  out  DATA_W  captured register value

## Operation
- States: IDLE, FETCH, SEND.
- IDLE: busy=0, out_valid=0. start=1 → FETCH, idx←0, rd_addr←0.
- FETCH (one cycle): rd_addr=idx stable; at end of cycle out_data←(ZERO_X0 && idx==0) ? 0 : rd_data, out_addr←idx, out_valid←1 → SEND.
- SEND: out_valid, out_data, out_addr held stable until out_valid && out_ready. On handshake: if idx==REG_COUNT-1 → IDLE, out_valid←0, done←1 for one cycle; else idx←idx+1, rd_addr←idx+1, out_valid←0 → FETCH.
- abort=1 in FETCH or SEND → IDLE next edge, out_valid←0, no done; abort has priority over a same-cycle handshake. abort in IDLE ignored.
- start while busy ignored. start and abort both high in IDLE: start wins.
- Data is not a snapshot: a bank write to a register before its FETCH cycle is reflected; after capture it is not.
- Reset values: busy=0, done=0, out_valid=0, rd_addr=0, out_addr=0, out_data=0, state IDLE. Reset asserted mid-run: all outputs to reset values immediately (asynchronous), no done.

## Timing
- start sampled at edge E0 → busy=1 and rd_addr=0 after E0; out_valid=1 after E1.
- Per word: 1 FETCH cycle + ≥1 SEND cycle; with out_ready tied high, a word is emitted every 2 cycles, full 32-word dump takes 64 cycles from E0 to last handshake; done high in the cycle following the last handshake edge, busy low in that same cycle.
- New start accepted in the same cycle done is high (state is IDLE).
- idx counter is ADDR_W+1 bits wide internally so REG_COUNT=2**ADDR_W terminates without wrap; rd_addr is its low ADDR_W bits.

## Structure
- Shared package: state enum (IDLE/FETCH/SEND) and default widths DATA_W/ADDR_W, shared with the register bank.
- No sub-module needed; single FSM plus index counter and output register. The register bank is instantiated only in the bench.

## Test plan
- Reset then start with bank preloaded r[i]=i*3+100, out_ready=1 → 32 words, out_addr 0..31, out_data 0 (x0), 103, 106, …, 193; done one cycle after addr 31 handshake; 64 cycles E0 to last handshake.
- Backpressure: out_ready low for 5 cycles on addr 7 → out_valid, out_addr=7, out_data=121 held stable; addr 8 follows after ready rises; no word lost or duplicated.
- abort asserted during SEND of addr 12 with out_ready=1 same cycle → no further words, out_valid=0 next cycle, busy=0, done never pulses.
- start pulsed again at addr 5 while busy → ignored, sequence continues 6..31, single done.
- Bank write r[20]←0xDEADBEEF while engine is at addr 10 → addr 20 emits 0xDEADBEEF; write to r[3] at the same time → addr 3 value unchanged in stream.
- rst_n dropped mid-SEND at addr 9 → out_valid, busy, rd_addr, out_data go 0 asynchronously; after release, start re-runs from addr 0.

Source files
------------

// File: rtl/br_dump_pkg.sv
// br_dump_pkg: shared widths and FSM state type for the register-bank dump engine.
package br_dump_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;
endpackage

// File: rtl/br_dump.sv
// br_dump: walks the register bank read port and streams each word with its address.
module br_dump
  import br_dump_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int REG_COUNT = 32,
  parameter bit ZERO_X0   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);
  // One extra index bit so REG_COUNT == 2**ADDR_W ends without wrapping.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               hs;
  assign hs = valid_q && out_ready;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = (ZERO_X0 && idx_q == '0) ? '0 : rd_data;
          addr_d  = idx_q[ADDR_W-1:0];
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (hs) begin
          valid_d = 1'b0;
          state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_FETCH;
          done_d  = (idx_q == LAST_IDX);
          idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign rd_addr   = idx_q[ADDR_W-1:0];
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
endmodule

// File: tb/tb_br_dump.sv
// tb_br_dump: directed vectors against a behavioural register bank and expected-value table.
module tb_br_dump;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic [31:0] bank [32];
  logic [31:0] exp_d [32];
  logic [4:0]  q_a [$];
  logic [31:0] q_d [$];
  int n_vec = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_hs = 0, e0 = 0;
  logic done_busy = 1'b0;

  br_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;
  assign rd_data = bank[rd_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Pre-edge values seen here are exactly what the DUT acts on at this edge.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && !abort) begin
      q_a.push_back(out_addr);
      q_d.push_back(out_data);
      last_hs <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_busy <= busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      bank[i]  = 32'(i * 3 + 100);
      exp_d[i] = (i == 0) ? 32'd0 : 32'(i * 3 + 100);
    end
  endtask

  task automatic clear();
    q_a.delete();
    q_d.delete();
    done_cnt = 0;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_send(input logic [4:0] a);
    int n = 0;
    while (!(out_valid && out_addr == a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_send_%0d", a), 64'(out_valid && out_addr == a), 64'd1);
  endtask

  task automatic check_seq(input string tag, input int n);
    chk({tag, "_nwords"}, 64'(q_a.size()), 64'(n));
    for (int i = 0; i < q_a.size() && i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(q_a[i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(q_d[i]), 64'(exp_d[i]));
    end
  endtask

  initial begin
    preload();
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    abort = 1'b0;

    // full dump, ready tied high
    clear();
    kick();
    chk("e0_busy", 64'(busy), 64'd1);
    chk("e0_rd_addr", 64'(rd_addr), 64'd0);
    chk("e0_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("e1_valid", 64'(out_valid), 64'd1);
    wait_done();
    @(negedge clk);
    check_seq("full", 32);
    chk("full_last_hs", 64'(last_hs - e0), 64'd63);
    chk("full_done_cyc", 64'(done_cyc - e0), 64'd64);
    chk("full_done_busy", 64'(done_busy), 64'd0);
    chk("full_done_cnt", 64'(done_cnt), 64'd1);

    // backpressure on address 7
    clear();
    kick();
    for (int n = 0; n < 400 && !(busy && !out_valid && rd_addr == 5'd7); n++) @(negedge clk);
    chk("bp_reach7", 64'(rd_addr), 64'd7);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_addr%0d", k), 64'(out_addr), 64'd7);
      chk($sformatf("bp_data%0d", k), 64'(out_data), 64'd121);
    end
    out_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check_seq("bp", 32);

    // abort in SEND of address 12 with a same-cycle ready
    clear();
    kick();
    wait_send(5'd12);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("ab_valid", 64'(out_valid), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    repeat (80) @(negedge clk);
    check_seq("ab", 12);
    chk("ab_done_cnt", 64'(done_cnt), 64'd0);

    // start while busy is ignored
    clear();
    kick();
    wait_send(5'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    check_seq("rs", 32);
    chk("rs_done_cnt", 64'(done_cnt), 64'd1);
    chk("rs_busy", 64'(busy), 64'd0);

    // bank writes mid-run: later register seen, earlier one already captured
    clear();
    kick();
    wait_send(5'd10);
    bank[20]  = 32'hDEADBEEF;
    bank[3]   = 32'h0000_0055;
    exp_d[20] = 32'hDEADBEEF;
    wait_done();
    @(negedge clk);
    check_seq("wr", 32);
    preload();

    // asynchronous reset in SEND of address 9
    clear();
    kick();
    wait_send(5'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_rd_addr", 64'(rd_addr), 64'd0);
    chk("ar_out_data", 64'(out_data), 64'd0);
    chk("ar_out_addr", 64'(out_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_done_cnt", 64'(done_cnt), 64'd0);
    clear();
    kick();
    wait_done();
    @(negedge clk);
    check_seq("ar", 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
